// File: rtl/iob_eth_frame_arbiter.sv
// Round-robin frame arbiter: grants one input stream for a whole frame (until its
// last beat is accepted) and forwards it to a single output stream.
module iob_eth_frame_arbiter #(
  parameter int PORTS  = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PORTS*DATA_W-1:0]   in_data,
  input  logic [PORTS-1:0]          in_valid,
  input  logic [PORTS-1:0]          in_last,
  output logic [PORTS-1:0]          in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [$clog2(PORTS)-1:0]  grant_encoded,
  output logic                      busy
);

  localparam int GW = $clog2(PORTS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [GW-1:0]   last_grant_reg, last_grant_next;
  logic [GW-1:0]   winner;
  logic            found;
  int              scan_idx;
  logic            frame_end;
  logic [DATA_W-1:0] data_arr [PORTS];

  generate
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_slice
      assign data_arr[gi] = in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan starts just after the previous winner and wraps, giving round-robin order.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 1; k <= PORTS; k++) begin
      scan_idx = int'(last_grant_reg) + k;
      if (scan_idx >= PORTS) scan_idx = scan_idx - PORTS;
      if (!found && in_valid[scan_idx[GW-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[GW-1:0];
      end
    end
  end

  assign busy          = (state_reg == BUSY);
  assign grant_encoded = grant_reg;

  // Beats are blocked while rst is high so an abandoned frame transfers nothing.
  always_comb begin
    in_ready  = '0;
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (busy) begin
      out_data  = data_arr[grant_reg];
      out_valid = in_valid[grant_reg] & ~rst;
      out_last  = in_last[grant_reg];
      in_ready[grant_reg] = out_ready & ~rst;
    end
  end

  assign frame_end = out_valid & out_ready & out_last;

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next      = BUSY;
          grant_next      = winner;
          last_grant_next = winner;
        end
      end
      BUSY: begin
        if (frame_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(PORTS - 1);
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

endmodule
